// File: rtl/uart_program_loader.sv
// uart_program_loader
//   Receives a program image over an 8N1 UART line and writes it into an
//   instruction memory, holding the core in reset until the load is done.
//   Wire format: one header byte N (word count), then N 32-bit words sent
//   little-endian, four bytes per word.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   rx           serial input, idle high, LSB first
//   o_we         one-cycle instruction-memory write strobe
//   o_addr       word address of the write (wraps modulo 2^ADDR_WIDTH)
//   o_wdata      32-bit instruction word of the write
//   o_core_rst_n active-low core reset, released once the load completes
//   o_busy       high from header acceptance until the load completes
//   o_err        sticky framing-error flag
module uart_program_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_WIDTH   = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx,
    output logic                  o_we,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [31:0]           o_wdata,
    output logic                  o_core_rst_n,
    output logic                  o_busy,
    output logic                  o_err
);

    // A bit period of one cycle still needs a non-zero half-bit wait.
    localparam int HALF = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;
    localparam int CW   = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {LD_HDR, LD_DATA, LD_DONE} ld_state_t;

    rx_state_t       rx_state, rx_next;
    ld_state_t       ld_state, ld_next;
    logic            rx_meta, rx_sync, rx_prev;
    logic [1:0]      sync_cnt;
    logic            sync_ready;
    logic [CW-1:0]   clk_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic            byte_valid;
    logic            half_tick, bit_tick, clear_cnt;
    logic [7:0]      words_left;
    logic [1:0]      byte_idx;
    logic [23:0]     word_buf;
    logic [ADDR_WIDTH-1:0] word_idx;

    // Two-flop synchronizer plus a delayed copy for edge detection. The
    // flops reset to the idle level so reset release never looks like a
    // start edge; sync_cnt keeps the receiver blind until two clocks of
    // real rx samples have passed through.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            sync_cnt <= 2'd0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            if (!sync_ready) begin
                sync_cnt <= sync_cnt + 2'd1;
            end
        end
    end

    assign sync_ready = (sync_cnt == 2'd2);

    // Receiver state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
        end else begin
            rx_state <= rx_next;
        end
    end

    // Receiver next-state: the start bit is re-checked half a bit in, so a
    // short low glitch falls back to idle without producing a byte.
    always_comb begin
        rx_next   = rx_state;
        half_tick = (clk_cnt == HALF_LAST);
        bit_tick  = (clk_cnt == BIT_LAST);
        clear_cnt = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                clear_cnt = 1'b1;
                if (sync_ready && rx_prev && !rx_sync) rx_next = RX_START;
            end
            RX_START: begin
                if (half_tick) begin
                    clear_cnt = 1'b1;
                    rx_next   = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                clear_cnt = bit_tick;
                if (bit_tick && bit_idx == 3'd7) rx_next = RX_STOP;
            end
            RX_STOP: begin
                clear_cnt = bit_tick;
                if (bit_tick) rx_next = RX_IDLE;
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    // Receiver datapath: bit timer, LSB-first shifter, and the stop-bit
    // verdict (byte strobe on a good stop, sticky error on a bad one).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_cnt    <= '0;
            bit_idx    <= 3'd0;
            shift      <= 8'd0;
            byte_valid <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            clk_cnt    <= clear_cnt ? '0 : clk_cnt + 1'b1;
            byte_valid <= 1'b0;
            if (rx_state == RX_START) begin
                bit_idx <= 3'd0;
            end
            if (rx_state == RX_DATA && bit_tick) begin
                shift   <= {rx_sync, shift[7:1]};
                bit_idx <= bit_idx + 3'd1;
            end
            if (rx_state == RX_STOP && bit_tick) begin
                if (rx_sync) byte_valid <= 1'b1;
                else         o_err      <= 1'b1;
            end
        end
    end

    // Loader state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_state <= LD_HDR;
        end else begin
            ld_state <= ld_next;
        end
    end

    // Loader next-state and status outputs. Leaving DATA is keyed off the
    // final write strobe itself, so the core reset releases one cycle
    // after that strobe.
    always_comb begin
        ld_next      = ld_state;
        o_busy       = 1'b0;
        o_core_rst_n = 1'b0;
        case (ld_state)
            LD_HDR: begin
                if (byte_valid) ld_next = (shift == 8'd0) ? LD_DONE : LD_DATA;
            end
            LD_DATA: begin
                o_busy = 1'b1;
                if (o_we && words_left == 8'd0) ld_next = LD_DONE;
            end
            LD_DONE: begin
                o_core_rst_n = 1'b1;
            end
            default: ld_next = LD_HDR;
        endcase
    end

    // Loader datapath: little-endian word assembly and the write port.
    // o_addr/o_wdata are only updated on a write so they hold in between.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_we       <= 1'b0;
            o_addr     <= '0;
            o_wdata    <= 32'd0;
            words_left <= 8'd0;
            byte_idx   <= 2'd0;
            word_buf   <= 24'd0;
            word_idx   <= '0;
        end else begin
            o_we <= 1'b0;
            if (ld_state == LD_HDR && byte_valid) begin
                words_left <= shift;
                byte_idx   <= 2'd0;
            end
            if (ld_state == LD_DATA && byte_valid) begin
                byte_idx <= byte_idx + 2'd1;
                case (byte_idx)
                    2'd0: word_buf[7:0]   <= shift;
                    2'd1: word_buf[15:8]  <= shift;
                    2'd2: word_buf[23:16] <= shift;
                    default: begin
                        o_we       <= 1'b1;
                        o_wdata    <= {shift, word_buf};
                        o_addr     <= word_idx;
                        word_idx   <= word_idx + 1'b1;
                        words_left <= words_left - 8'd1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// tb_uart_program_loader
//   Directed bench for uart_program_loader with CLKS_PER_BIT=4 and
//   ADDR_WIDTH=6. Frames are driven bit by bit on rx; a negedge monitor
//   collects every write strobe and the cycle the core reset releases.
module tb_uart_program_loader;

    localparam int CPB = 4;
    localparam int AW  = 6;
    // Launch of the start bit to the loader reacting to its byte:
    // 2 sync flops + 1 edge detect + CPB/2 + 9 bit periods + 1 strobe cycle.
    localparam int BYTE_LAT = 3 + CPB / 2 + 9 * CPB + 1;

    typedef struct {
        logic [7:0]    b0, b1, b2, b3;
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx = 1'b1;
    logic          o_we;
    logic [AW-1:0] o_addr;
    logic [31:0]   o_wdata;
    logic          o_core_rst_n;
    logic          o_busy;
    logic          o_err;

    int passed = 0;
    int total = 0;
    int cyc = 0;
    int last_start = 0;
    int last_we_cyc = -1;
    int rise_cyc = -1;
    bit busy_seen = 1'b0;
    logic [AW-1:0] addr_q[$];
    logic [31:0]   data_q[$];

    uart_program_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .o_we(o_we), .o_addr(o_addr),
        .o_wdata(o_wdata), .o_core_rst_n(o_core_rst_n), .o_busy(o_busy),
        .o_err(o_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_we) begin
            addr_q.push_back(o_addr);
            data_q.push_back(o_wdata);
            last_we_cyc = cyc;
        end
        if (o_core_rst_n && rise_cyc < 0) rise_cyc = cyc;
        if (o_busy) busy_seen = 1'b1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic holdBit(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    // One 8N1 frame followed by one idle bit period.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
        @(posedge clk);
        #1;
        last_start = cyc;
        holdBit(1'b0);
        for (int i = 0; i < 8; i++) holdBit(data[i]);
        holdBit(stop_bit);
        holdBit(1'b1);
    endtask

    task automatic sendWord(input vec_t v);
        applyStimulus(v.b0, 1'b1);
        applyStimulus(v.b1, 1'b1);
        applyStimulus(v.b2, 1'b1);
        applyStimulus(v.b3, 1'b1);
    endtask

    task automatic expectWrite(input string name, input logic [AW-1:0] ea, input logic [31:0] ed);
        int waited = 0;
        while (addr_q.size() == 0 && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (addr_q.size() == 0) begin
            total++;
            $display("[TB] FAIL %s_timeout: got no o_we strobe, expected one", name);
        end else begin
            checkOutput({name, "_addr"}, 32'(addr_q.pop_front()), 32'(ea));
            checkOutput({name, "_data"}, data_q.pop_front(), ed);
        end
    endtask

    task automatic clearMonitor();
        addr_q.delete();
        data_q.delete();
        rise_cyc = -1;
        last_we_cyc = -1;
        busy_seen = 1'b0;
    endtask

    task automatic resetDut();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clearMonitor();
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t vecs[2];
        vec_t w;
        vec_t bad_vec;
        int t0;

        vecs[0] = '{b0: 8'h13, b1: 8'h05, b2: 8'h00, b3: 8'h00, addr: 6'd0, data: 32'h0000_0513};
        vecs[1] = '{b0: 8'h93, b1: 8'h05, b2: 8'h10, b3: 8'h00, addr: 6'd1, data: 32'h0010_0593};

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_we", 32'(o_we), 32'd0);
        checkOutput("rst_addr", 32'(o_addr), 32'd0);
        checkOutput("rst_wdata", o_wdata, 32'd0);
        checkOutput("rst_core_rst_n", 32'(o_core_rst_n), 32'd0);
        checkOutput("rst_busy", 32'(o_busy), 32'd0);
        checkOutput("rst_err", 32'(o_err), 32'd0);
        clearMonitor();
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // One-cycle glitch in idle: no byte, no error.
        rx = 1'b0;
        @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("glitch_err", 32'(o_err), 32'd0);
        checkOutput("glitch_busy", 32'(o_busy), 32'd0);
        checkOutput("glitch_core", 32'(o_core_rst_n), 32'd0);

        // Two-word load from the vector table.
        applyStimulus(8'h02, 1'b1);
        checkOutput("hdr2_busy", 32'(o_busy), 32'd1);
        for (int i = 0; i < 2; i++) begin
            sendWord(vecs[i]);
            expectWrite($sformatf("load2_w%0d", i), vecs[i].addr, vecs[i].data);
        end
        checkOutput("load2_we_lat", 32'(last_we_cyc), 32'(last_start + BYTE_LAT));
        checkOutput("load2_rise", 32'(rise_cyc), 32'(last_we_cyc + 1));
        checkOutput("load2_core", 32'(o_core_rst_n), 32'd1);
        checkOutput("load2_busy", 32'(o_busy), 32'd0);
        checkOutput("hold_addr", 32'(o_addr), 32'd1);
        checkOutput("hold_wdata", o_wdata, 32'h0010_0593);

        // DONE ignores further bytes but still flags framing errors.
        sendWord(vecs[0]);
        checkOutput("done_no_we", 32'(addr_q.size()), 32'd0);
        checkOutput("done_core", 32'(o_core_rst_n), 32'd1);
        checkOutput("done_err0", 32'(o_err), 32'd0);
        applyStimulus(8'h12, 1'b0);
        checkOutput("done_err1", 32'(o_err), 32'd1);

        // Header 0: straight to DONE.
        resetDut();
        applyStimulus(8'h00, 1'b1);
        t0 = last_start;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("hdr0_rise", 32'(rise_cyc), 32'(t0 + BYTE_LAT));
        checkOutput("hdr0_busy_seen", 32'(busy_seen), 32'd0);
        checkOutput("hdr0_no_we", 32'(addr_q.size()), 32'd0);
        checkOutput("hdr0_busy", 32'(o_busy), 32'd0);

        // Framing error in the middle of a word.
        resetDut();
        applyStimulus(8'h02, 1'b1);
        applyStimulus(vecs[0].b0, 1'b1);
        applyStimulus(8'h55, 1'b0);
        checkOutput("ferr_set", 32'(o_err), 32'd1);
        checkOutput("ferr_no_we", 32'(addr_q.size()), 32'd0);
        applyStimulus(vecs[0].b1, 1'b1);
        applyStimulus(vecs[0].b2, 1'b1);
        applyStimulus(vecs[0].b3, 1'b1);
        expectWrite("ferr_w0", vecs[0].addr, vecs[0].data);
        sendWord(vecs[1]);
        expectWrite("ferr_w1", vecs[1].addr, vecs[1].data);
        checkOutput("ferr_sticky", 32'(o_err), 32'd1);
        checkOutput("ferr_core", 32'(o_core_rst_n), 32'd1);

        // Reset in the middle of a word discards partial data.
        resetDut();
        applyStimulus(8'h03, 1'b1);
        sendWord(vecs[1]);
        expectWrite("mid_w0", 6'd0, 32'h0010_0593);
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_busy", 32'(o_busy), 32'd0);
        checkOutput("mid_rst_wdata", o_wdata, 32'd0);
        checkOutput("mid_rst_core", 32'(o_core_rst_n), 32'd0);
        checkOutput("mid_rst_we", 32'(o_we), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        clearMonitor();
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        applyStimulus(8'h01, 1'b1);
        w = '{b0: 8'hAA, b1: 8'hBB, b2: 8'hCC, b3: 8'hDD, addr: 6'd0, data: 32'hDDCC_BBAA};
        sendWord(w);
        expectWrite("restart_w0", w.addr, w.data);
        checkOutput("restart_rise", 32'(rise_cyc), 32'(last_we_cyc + 1));
        sendWord(w);
        checkOutput("restart_single", 32'(addr_q.size()), 32'd0);

        // 65 words: the last one wraps to address 0.
        resetDut();
        applyStimulus(8'h41, 1'b1);
        for (int i = 0; i < 65; i++) begin
            bad_vec.b0 = 8'(i);
            bad_vec.b1 = 8'(i) ^ 8'h5A;
            bad_vec.b2 = 8'(i + 3);
            bad_vec.b3 = ~8'(i);
            bad_vec.addr = 6'(i % 64);
            bad_vec.data = {bad_vec.b3, bad_vec.b2, bad_vec.b1, bad_vec.b0};
            if (i == 64) checkOutput("wrap_core_before", 32'(o_core_rst_n), 32'd0);
            sendWord(bad_vec);
            expectWrite($sformatf("wrap_w%0d", i), bad_vec.addr, bad_vec.data);
        end
        checkOutput("wrap_rise", 32'(rise_cyc), 32'(last_we_cyc + 1));
        checkOutput("wrap_busy", 32'(o_busy), 32'd0);
        checkOutput("wrap_last_addr", 32'(o_addr), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
